xrbus_integrity_stream: RTL and testbench
=========================================

// Module: xrbus_integrity_stream
// PURPOSE
//  Streaming, parametrised XR-BUS frame integrity stage. Frames arrive as BEATS beats of DATA_W over valid/ready.
//  Each frame is held in a store-and-forward buffer, version-range checked, signed with a plain or keyed XOR-fold
//  signature, then forwarded or dropped. Sits between XR-BUS frame assembly and the downstream router.
// PARAMETERS
//  DATA_W     256  beat width in bits; also the signature width
//  BEATS      16   beats per frame (>=2); buffer depth
//  VER_BEAT   6    beat index holding the 8-bit version field (< BEATS)
//  VER_LSB    18   LSB of version field within that beat (VER_LSB+7 < DATA_W)
//  SIG_BEATS  3    beats 0..SIG_BEATS-1 folded into the signature (1..BEATS)
//  CNT_W      16   width of the saturating frame counters
// PORTS
//  clk               in   1        clock
//  rst_n             in   1        async active-low reset
//  protocol_version  in   8        max accepted version
//  min_compatible    in   8        min accepted version
//  sig_keyed         in   1        1: XOR signing_key into signature
//  signing_key       in   DATA_W   signature key
//  in_valid          in   1        input beat valid
//  in_ready          out  1        input beat ready
//  in_data           in   DATA_W   input beat
//  in_last           in   1        final beat of frame
//  out_valid         out  1        output beat valid
//  out_ready         in   1        output beat ready
//  out_data          out  DATA_W   output beat
//  out_last          out  1        final output beat
//  frame_version     out  8        version of last evaluated frame
//  version_compatible out 1        result of last evaluation
//  frame_signature   out  DATA_W   signature of last accepted frame
//  sig_valid         out  1        1-cycle pulse: frame_signature updated
//  reject_pulse      out  1        1-cycle pulse: frame dropped (version or length)
//  length_err        out  1        1-cycle pulse: frame length != BEATS
//  frames_ok         out  CNT_W    accepted-frame count, saturating
//  frames_rej        out  CNT_W    rejected-frame count, saturating
// BEHAVIOUR
//  Reset: all outputs 0; state COLLECT; beat count 0; signature accumulator 0.
//  Handshake: transfer when valid&&ready. out_data/out_last stay stable while out_valid && !out_ready.
//  States:
//   COLLECT: in_ready=1; write beat[cnt]; cnt++; acc ^= in_data while cnt<SIG_BEATS.
//            in_last at cnt==BEATS-1 -> DECIDE.
//            in_last at cnt<BEATS-1 -> length_err + reject_pulse; frames_rej++; cnt=0; stay in COLLECT.
//            beat cnt==BEATS-1 without in_last -> length_err + reject_pulse; frames_rej++ -> DISCARD.
//   DISCARD: in_ready=1; drop beats until in_last is accepted -> COLLECT, cnt=0. No extra pulse or count.
//   DECIDE (1 cycle, in_ready=0):
//            ver = buf[VER_BEAT][VER_LSB+:8]; frame_version<=ver.
//            ok = (ver>=min_compatible)&&(ver<=protocol_version), unsigned 8-bit, config sampled this cycle.
//            version_compatible<=ok.
//            ok: frame_signature <= acc ^ (sig_keyed ? signing_key : 0); sig_valid=1; frames_ok++ -> SEND.
//            !ok: reject_pulse=1; frames_rej++; frame_signature unchanged -> COLLECT.
//   SEND:    in_ready=0; out_valid=1; out_data=buf[rd]; out_last=(rd==BEATS-1).
//            Last beat accepted -> COLLECT; rd=0, cnt=0, acc=0.
//  Latency: last input beat at cycle T -> DECIDE at T+1 -> first out_valid at T+2 (no input beats accepted T+1..end of SEND).
//  Acc cleared on entry to COLLECT; a short (early in_last) frame never updates frame_signature.
//  Counters saturate at 2^CNT_W-1; no wrap.
//  in_valid=0 in COLLECT holds cnt; backpressure in SEND stalls indefinitely without loss.
//  Async reset mid-frame or mid-SEND: partial frame discarded, out_valid drops immediately, counters cleared.
// TESTING
//  1 DATA_W=256,BEATS=16: beat6[25:18]=8'h03, min=1, max=5, beats0..2=A,B,C, sig_keyed=0
//    -> 16 beats out in order, out_last on beat 15, sig=A^B^C, sig_valid at T+1, frames_ok=1.
//  2 Same frame, version 8'h07 (>max) or 8'h00 (<min)
//    -> no out_valid; reject_pulse at T+1; version_compatible=0; frames_rej=1.
//  3 in_last on beat 9 -> length_err+reject at that beat; next full valid frame accepted normally.
//    No in_last by beat 15 -> DISCARD until in_last; length_err once.
//  4 sig_keyed=1, key=K -> frame_signature=A^B^C^K. Version==min and version==max both accepted.
//  5 out_ready toggled 1/0 random during SEND -> data unchanged while stalled; in_ready=0 throughout.
//    Two back-to-back frames both delivered intact.
//  6 rst_n low during beat 8 of SEND -> outputs 0 immediately; next frame processed normally.
//    CNT_W=2: 5 rejects -> frames_rej=3.

Source files
------------

// File: rtl/xrbus_integrity_stream.sv
// xrbus_integrity_stream
// Store-and-forward integrity stage for XR-BUS frames. Each frame of BEATS beats
// is buffered, its version field is range-checked, and beats 0..SIG_BEATS-1 are
// XOR-folded (optionally keyed) into a signature. Compatible frames are replayed
// downstream in order. Short, long or incompatible frames are dropped and counted.
//
// Pulse timing: length_err/reject_pulse for a bad length fire in the same cycle
// as the offending input beat. sig_valid/reject_pulse for the version decision
// fire in the decision cycle. The registered results (frame_signature,
// frame_version, version_compatible, counters) are visible from the next cycle.
module xrbus_integrity_stream #(
  parameter int DATA_W    = 256,
  parameter int BEATS     = 16,
  parameter int VER_BEAT  = 6,
  parameter int VER_LSB   = 18,
  parameter int SIG_BEATS = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        protocol_version,
  input  logic [7:0]        min_compatible,
  input  logic              sig_keyed,
  input  logic [DATA_W-1:0] signing_key,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [7:0]        frame_version,
  output logic              version_compatible,
  output logic [DATA_W-1:0] frame_signature,
  output logic              sig_valid,
  output logic              reject_pulse,
  output logic              length_err,
  output logic [CNT_W-1:0]  frames_ok,
  output logic [CNT_W-1:0]  frames_rej
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DISCARD = 2'd1,
    DECIDE  = 2'd2,
    SEND    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;

  // Held low through reset so every output, including in_ready, reads 0 while
  // rst_n is asserted; set on the first clock after release.
  logic              run;

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     rd;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] buf_mem [BEATS];

  logic              in_fire;
  logic              out_fire;
  logic              at_last;
  logic              rd_last;
  logic              sig_beat;
  logic              short_frame;
  logic              long_frame;
  logic [7:0]        ver;
  logic              ver_ok;

  // Handshake and per-beat qualifiers shared by the FSM and datapath.
  always_comb begin
    in_fire     = in_valid && in_ready;
    out_fire    = out_valid && out_ready;
    at_last     = (cnt == LAST_IDX);
    rd_last     = (rd == LAST_IDX);
    sig_beat    = (32'(cnt) < 32'(SIG_BEATS));
    short_frame = (state == COLLECT) && in_fire && in_last && !at_last;
    long_frame  = (state == COLLECT) && in_fire && !in_last && at_last;
    ver         = buf_mem[VER_BEAT][VER_LSB +: 8];
    ver_ok      = (ver >= min_compatible) && (ver <= protocol_version);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      // NOTE: every clocked assignment uses <= so all flops sample the same
      // pre-edge values; a blocking '=' here would make results order-dependent.
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    unique case (state)
      COLLECT: begin
        if (in_fire && in_last && at_last) state_nx = DECIDE;
        else if (long_frame)               state_nx = DISCARD;
      end
      DISCARD: begin
        if (in_fire && in_last) state_nx = COLLECT;
      end
      DECIDE: begin
        state_nx = ver_ok ? SEND : COLLECT;
      end
      SEND: begin
        if (out_fire && rd_last) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // Output decode: handshakes, replay beat and event pulses.
  always_comb begin
    in_ready     = run && ((state == COLLECT) || (state == DISCARD));
    out_valid    = (state == SEND);
    out_data     = (state == SEND) ? buf_mem[rd] : '0;
    out_last     = (state == SEND) && rd_last;
    sig_valid    = (state == DECIDE) && ver_ok;
    length_err   = short_frame || long_frame;
    reject_pulse = ((state == DECIDE) && !ver_ok) || short_frame || long_frame;
  end

  // Frame buffer write port.
  // NOTE: the buffer has no reset; every entry read is first written by the
  // frame being collected, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if ((state == COLLECT) && in_fire) begin
      buf_mem[cnt] <= in_data;
    end
  end

  // Beat counters, signature accumulator and decision results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run                <= 1'b0;
      cnt                <= '0;
      rd                 <= '0;
      acc                <= '0;
      frame_version      <= '0;
      version_compatible <= 1'b0;
      frame_signature    <= '0;
    end else begin
      run <= 1'b1;
      unique case (state)
        COLLECT: begin
          if (in_fire) begin
            if (short_frame || long_frame) begin
              // A bad-length frame never contributes to a signature.
              cnt <= '0;
              acc <= '0;
            end else begin
              if (sig_beat) acc <= acc ^ in_data;
              cnt <= at_last ? '0 : cnt + 1'b1;
            end
          end
        end
        DISCARD: begin
          cnt <= '0;
          acc <= '0;
        end
        DECIDE: begin
          frame_version      <= ver;
          version_compatible <= ver_ok;
          if (ver_ok) begin
            frame_signature <= acc ^ (sig_keyed ? signing_key : '0);
          end else begin
            acc <= '0;
          end
          rd  <= '0;
          cnt <= '0;
        end
        SEND: begin
          if (out_fire) begin
            if (rd_last) begin
              rd  <= '0;
              cnt <= '0;
              acc <= '0;
            end else begin
              rd <= rd + 1'b1;
            end
          end
        end
        default: begin
          cnt <= '0;
          rd  <= '0;
          acc <= '0;
        end
      endcase
    end
  end

  // Saturating accepted / rejected frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_ok  <= '0;
      frames_rej <= '0;
    end else begin
      if (sig_valid && (frames_ok != {CNT_W{1'b1}})) begin
        frames_ok <= frames_ok + 1'b1;
      end
      if (reject_pulse && (frames_rej != {CNT_W{1'b1}})) begin
        frames_rej <= frames_rej + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xrbus_integrity_stream.sv
// Testbench for xrbus_integrity_stream. A frame-level queue model predicts every
// output each cycle; a second instance with 2-bit counters exercises saturation.
module tb_xrbus_integrity_stream;

  localparam int DATA_W    = 256;
  localparam int BEATS     = 16;
  localparam int VER_BEAT  = 6;
  localparam int VER_LSB   = 18;
  localparam int SIG_BEATS = 3;
  localparam int CNT_W     = 16;
  localparam int SAT_W     = 2;

  localparam logic [DATA_W-1:0] BEAT_A = {8{32'h1111_1111}};
  localparam logic [DATA_W-1:0] BEAT_B = {8{32'h2222_2222}};
  localparam logic [DATA_W-1:0] BEAT_C = {8{32'h4444_4444}};
  localparam logic [DATA_W-1:0] KEY    = {8{32'h0F0F_0F0F}};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        protocol_version;
  logic [7:0]        min_compatible;
  logic              sig_keyed;
  logic [DATA_W-1:0] signing_key;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [7:0]        frame_version;
  logic              version_compatible;
  logic [DATA_W-1:0] frame_signature;
  logic              sig_valid;
  logic              reject_pulse;
  logic              length_err;
  logic [CNT_W-1:0]  frames_ok;
  logic [CNT_W-1:0]  frames_rej;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [DATA_W-1:0] s_out_data;
  logic              s_out_last;
  logic [7:0]        s_frame_version;
  logic              s_version_compatible;
  logic [DATA_W-1:0] s_frame_signature;
  logic              s_sig_valid;
  logic              s_reject_pulse;
  logic              s_length_err;
  logic [SAT_W-1:0]  s_frames_ok;
  logic [SAT_W-1:0]  s_frames_rej;

  always #5 clk = ~clk;

  xrbus_integrity_stream #(
    .DATA_W(DATA_W), .BEATS(BEATS), .VER_BEAT(VER_BEAT), .VER_LSB(VER_LSB),
    .SIG_BEATS(SIG_BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .protocol_version(protocol_version), .min_compatible(min_compatible),
    .sig_keyed(sig_keyed), .signing_key(signing_key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_version(frame_version), .version_compatible(version_compatible),
    .frame_signature(frame_signature), .sig_valid(sig_valid),
    .reject_pulse(reject_pulse), .length_err(length_err),
    .frames_ok(frames_ok), .frames_rej(frames_rej)
  );

  xrbus_integrity_stream #(
    .DATA_W(DATA_W), .BEATS(BEATS), .VER_BEAT(VER_BEAT), .VER_LSB(VER_LSB),
    .SIG_BEATS(SIG_BEATS), .CNT_W(SAT_W)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .protocol_version(protocol_version), .min_compatible(min_compatible),
    .sig_keyed(sig_keyed), .signing_key(signing_key),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_last(s_out_last),
    .frame_version(s_frame_version), .version_compatible(s_version_compatible),
    .frame_signature(s_frame_signature), .sig_valid(s_sig_valid),
    .reject_pulse(s_reject_pulse), .length_err(s_length_err),
    .frames_ok(s_frames_ok), .frames_rej(s_frames_rej)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] frame_q[$];
  logic [DATA_W-1:0] exp_out[$];
  bit                m_run     = 0;
  bit                m_pending = 0;
  bit                m_discard = 0;
  logic [7:0]        m_ver     = '0;
  bit                m_compat  = 0;
  logic [DATA_W-1:0] m_sig     = '0;
  int                n_ok      = 0;
  int                n_rej     = 0;

  function automatic int sat(input int n, input int w);
    int lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  // Compare DUT outputs against the model on every falling edge, then advance it.
  always @(negedge clk) begin : compare
    logic              e_in_ready, e_out_valid, e_len, e_rej, e_sig, d_ok;
    logic [7:0]        d_ver;
    logic [DATA_W-1:0] d_sig;
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_pulses", {sig_valid, reject_pulse, length_err}, 0);
      check("rst_version", {frame_version, version_compatible}, 0);
      check("rst_signature", frame_signature, 0);
      check("rst_counters", {frames_ok, frames_rej, s_frames_ok, s_frames_rej}, 0);
      frame_q.delete(); exp_out.delete();
      m_run = 0; m_pending = 0; m_discard = 0;
      m_ver = '0; m_compat = 0; m_sig = '0; n_ok = 0; n_rej = 0;
    end else begin
      e_in_ready  = m_run && !m_pending && (exp_out.size() == 0);
      e_out_valid = !m_pending && (exp_out.size() > 0);
      e_len = 0; e_rej = 0; e_sig = 0; d_ok = 0; d_ver = '0; d_sig = '0;
      if (m_pending) begin
        d_ver = frame_q[VER_BEAT][VER_LSB +: 8];
        d_ok  = (d_ver >= min_compatible) && (d_ver <= protocol_version);
        for (int i = 0; i < SIG_BEATS; i++) d_sig = d_sig ^ frame_q[i];
        if (sig_keyed) d_sig = d_sig ^ signing_key;
        e_sig = d_ok;
        e_rej = !d_ok;
      end else if (in_valid && e_in_ready && !m_discard) begin
        e_len = (in_last && frame_q.size() < BEATS - 1) ||
                (!in_last && frame_q.size() == BEATS - 1);
        e_rej = e_len;
      end

      check("in_ready", in_ready, e_in_ready);
      check("out_valid", out_valid, e_out_valid);
      if (e_out_valid) begin
        check("out_data", out_data, exp_out[0]);
        check("out_last", out_last, exp_out.size() == 1);
      end
      check("sig_valid", sig_valid, e_sig);
      check("reject_pulse", reject_pulse, e_rej);
      check("length_err", length_err, e_len);
      check("frame_version", frame_version, m_ver);
      check("version_compatible", version_compatible, m_compat);
      check("frame_signature", frame_signature, m_sig);
      check("frames_ok", frames_ok, sat(n_ok, CNT_W));
      check("frames_rej", frames_rej, sat(n_rej, CNT_W));
      check("sat_frames_ok", s_frames_ok, sat(n_ok, SAT_W));
      check("sat_frames_rej", s_frames_rej, sat(n_rej, SAT_W));

      if (m_pending) begin
        m_pending = 0;
        m_ver     = d_ver;
        m_compat  = d_ok;
        if (d_ok) begin
          m_sig   = d_sig;
          n_ok++;
          exp_out = frame_q;
        end else begin
          n_rej++;
        end
        frame_q.delete();
      end else if (e_out_valid) begin
        if (out_ready) void'(exp_out.pop_front());
      end else if (in_valid && e_in_ready) begin
        if (m_discard) begin
          if (in_last) m_discard = 0;
        end else begin
          frame_q.push_back(in_data);
          if (in_last) begin
            if (frame_q.size() == BEATS) m_pending = 1;
            else begin n_rej++; frame_q.delete(); end
          end else if (frame_q.size() == BEATS) begin
            n_rej++; frame_q.delete(); m_discard = 1;
          end
        end
      end
      m_run = 1;
    end
  end

  // ---------------- stimulus ----------------
  bit rand_ready = 0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] beat_val(input int fid, input int i,
                                                 input logic [7:0] ver);
    logic [DATA_W-1:0] d;
    logic [7:0] f8 = 8'(fid);
    logic [7:0] i8 = 8'(i);
    if (fid == 0 && i == 0)      d = BEAT_A;
    else if (fid == 0 && i == 1) d = BEAT_B;
    else if (fid == 0 && i == 2) d = BEAT_C;
    else                         d = {8{f8, i8, 16'hC3A5}};
    if (i == VER_BEAT) d[VER_LSB +: 8] = ver;
    return d;
  endfunction

  task automatic put_beat(input logic [DATA_W-1:0] d, input logic l);
    int waited = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 1000) begin
        checks++; errors++;
        $display("FAIL in_handshake_timeout: got no in_ready expected ready within 1000 cycles");
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int fid, input logic [7:0] ver, input int n);
    for (int i = 0; i < n; i++) put_beat(beat_val(fid, i, ver), i == n - 1);
  endtask

  task automatic wait_idle();
    int waited = 0;
    do begin
      @(posedge clk); #2;
      waited++;
    end while ((m_pending || exp_out.size() != 0) && waited < 2000);
    if (waited >= 2000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy expected idle within 2000 cycles");
    end
  endtask

  initial begin
    protocol_version = 8'd5;
    min_compatible   = 8'd1;
    sig_keyed        = 1'b0;
    signing_key      = KEY;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Accepted frame, plain signature.
    send_frame(0, 8'h03, BEATS);
    wait_idle();
    check("lit_sig_plain", frame_signature, {8{32'h7777_7777}});
    check("lit_ok_1", frames_ok, 1);
    check("lit_ver_3", frame_version, 8'h03);

    // Version above max and below min.
    send_frame(0, 8'h07, BEATS);
    wait_idle();
    send_frame(0, 8'h00, BEATS);
    wait_idle();
    check("lit_rej_2", frames_rej, 2);
    check("lit_incompat", version_compatible, 0);
    check("lit_sig_kept", frame_signature, {8{32'h7777_7777}});

    // Short frame, recovery, long frame with discard, recovery.
    send_frame(1, 8'h02, 10);
    send_frame(1, 8'h02, BEATS);
    wait_idle();
    send_frame(2, 8'h04, 20);
    send_frame(2, 8'h04, BEATS);
    wait_idle();
    check("lit_rej_4", frames_rej, 4);
    check("lit_ok_3", frames_ok, 3);

    // Keyed signature; version at min and at max boundaries.
    sig_keyed = 1'b1;
    send_frame(0, 8'h01, BEATS);
    wait_idle();
    check("lit_sig_keyed", frame_signature, {8{32'h7878_7878}});
    send_frame(0, 8'h05, BEATS);
    wait_idle();
    check("lit_ok_5", frames_ok, 5);
    check("lit_ver_max", frame_version, 8'h05);
    sig_keyed = 1'b0;

    // Random output backpressure across two back-to-back frames.
    rand_ready = 1;
    send_frame(3, 8'h03, BEATS);
    send_frame(4, 8'h03, BEATS);
    wait_idle();
    rand_ready = 0;
    @(posedge clk); #1;
    check("lit_ok_7", frames_ok, 7);
    check("lit_sat_ok", s_frames_ok, 3);

    // Asynchronous reset while the ninth beat is being presented.
    send_frame(5, 8'h03, BEATS);
    begin
      int waited = 0;
      do begin
        @(posedge clk); #2;
        waited++;
      end while (exp_out.size() != BEATS - 8 && waited < 500);
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_now_out_valid", out_valid, 0);
    check("rst_now_out_data", out_data, 0);
    check("rst_now_frames_ok", frames_ok, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(6, 8'h02, BEATS);
    wait_idle();
    check("lit_ok_after_rst", frames_ok, 1);

    // Five rejects saturate the 2-bit counter at 3.
    for (int k = 0; k < 5; k++) begin
      send_frame(7, 8'h09, BEATS);
      wait_idle();
    end
    check("lit_rej_5", frames_rej, 5);
    check("lit_sat_rej", s_frames_rej, 3);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
